// File: rtl/task_pkg.sv
// Shared types and constants for the task session controller and its second-tick prescaler.
package task_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Default Master_Clock rate, i.e. the prescaler period of one second.
    localparam int unsigned SEC_TICK = 100_000_000;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 and flags the last count as a one-cycle tick.
module sec_tick_gen
    import task_pkg::*;
#(
    parameter int unsigned CLK_HZ = SEC_TICK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = cnt_width(CLK_HZ);
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/task_session_ctrl.sv
// Task session controller: grants the start detector, times a run in seconds and ends it on
// a sustained switch release or on the run time-out.
module task_session_ctrl
    import task_pkg::*;
#(
    parameter int unsigned  CLK_HZ      = SEC_TICK,
    parameter int unsigned  STOP_HOLD_S = 2,
    parameter int unsigned  MAX_RUN_S   = 63,
    parameter int unsigned  SYNC_STAGES = 2,
    localparam int unsigned EW          = $clog2(MAX_RUN_S + 1)
) (
    input  logic          Master_Clock,
    input  logic          Reset_n,
    input  logic          enable,
    input  logic          sw_in,
    input  logic          start_req,
    output logic          task_active,
    output logic          running,
    output logic          start_ack,
    output logic          stop_pulse,
    output logic          timed_out,
    output logic [EW-1:0] elapsed_s
);

    localparam int unsigned   LW     = cnt_width(STOP_HOLD_S + 1);
    localparam logic [EW-1:0] MAX_E  = EW'(MAX_RUN_S);
    localparam logic [LW-1:0] STOP_L = LW'(STOP_HOLD_S);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    logic                   tick;
    logic                   tick_clr;

    state_e        state_q, state_d;
    logic [EW-1:0] elapsed_q, elapsed_d, elapsed_inc;
    logic [LW-1:0] low_q, low_d;
    logic          timed_out_q, timed_out_d;
    logic          start_ack_q, start_ack_d;
    logic          stop_pulse_q, stop_pulse_d;
    logic          task_active_q, running_q;

    always_ff @(posedge Master_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk   (Master_Clock),
        .rst_n (Reset_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        elapsed_d    = elapsed_q;
        low_d        = low_q;
        timed_out_d  = timed_out_q;
        start_ack_d  = 1'b0;
        stop_pulse_d = 1'b0;
        tick_clr     = 1'b0;
        elapsed_inc  = (elapsed_q == MAX_E) ? elapsed_q : elapsed_q + EW'(1);

        if (!enable) begin
            // Abort: no stop_pulse, everything back to its idle value.
            state_d     = IDLE;
            elapsed_d   = '0;
            low_d       = '0;
            timed_out_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (start_req) begin
                        state_d     = RUN;
                        elapsed_d   = '0;
                        low_d       = '0;
                        timed_out_d = 1'b0;
                        start_ack_d = 1'b1;
                        tick_clr    = 1'b1;
                    end
                end
                RUN, RELEASE: begin
                    if (tick) begin
                        elapsed_d = elapsed_inc;
                        if (state_q == RELEASE) begin
                            low_d = low_q + LW'(1);
                        end
                    end
                    // Time-out outranks a switch return, which outranks the release hold.
                    if (elapsed_d == MAX_E) begin
                        state_d      = DONE;
                        timed_out_d  = 1'b1;
                        stop_pulse_d = 1'b1;
                    end else if (state_q == RUN) begin
                        if (!sw_s) begin
                            state_d = RELEASE;
                            low_d   = '0;
                        end
                    end else if (sw_s) begin
                        state_d = RUN;
                        low_d   = '0;
                    end else if (low_d == STOP_L) begin
                        state_d      = DONE;
                        stop_pulse_d = 1'b1;
                    end
                end
                DONE: begin
                    // Wait for start_req to drop so a held switch cannot re-trigger at once.
                    if (!start_req) begin
                        state_d     = ARMED;
                        timed_out_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Master_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            elapsed_q     <= '0;
            low_q         <= '0;
            timed_out_q   <= 1'b0;
            start_ack_q   <= 1'b0;
            stop_pulse_q  <= 1'b0;
            task_active_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            elapsed_q     <= elapsed_d;
            low_q         <= low_d;
            timed_out_q   <= timed_out_d;
            start_ack_q   <= start_ack_d;
            stop_pulse_q  <= stop_pulse_d;
            task_active_q <= (state_d == ARMED) || (state_d == RUN) || (state_d == RELEASE);
            running_q     <= (state_d == RUN) || (state_d == RELEASE);
        end
    end

    assign task_active = task_active_q;
    assign running     = running_q;
    assign start_ack   = start_ack_q;
    assign stop_pulse  = stop_pulse_q;
    assign timed_out   = timed_out_q;
    assign elapsed_s   = elapsed_q;

endmodule
